nmr_qsw_sequencer: RTL and testbench
====================================

Name: nmr_qsw_sequencer

Overview:
- Schedules the Q-switch damping pulse for every echo of a CPMG acquisition train.
- After START, it tracks each ACQ_WND acquisition window. When a window closes, it fires one QSW_PULSE with a programmable delay and width, then waits for the next window.
- Counts completed echoes and signals DONE after NUM_ECHO echoes.
- Sits between the pulse-programmer/ADC-window logic and the Q-switch driver, all on ADC_CLK.

Parameters:
- CNT_W, 16: width of the delay and width counters and config inputs.
- ECHO_W, 16: width of the echo counter and NUM_ECHO.

Ports:
- ADC_CLK  in  1  sole clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request; latches config and begins a train when idle.
- ABORT  in  1  level; forces return to IDLE.
- ACQ_WND  in  1  acquisition window, synchronous to ADC_CLK.
- QSW_DELAY  in  CNT_W  cycles from window close to pulse start.
- QSW_WIDTH  in  CNT_W  pulse length in cycles.
- NUM_ECHO  in  ECHO_W  echoes in the train.
- QSW_PULSE  out  1  registered Q-switch enable.
- BUSY  out  1  high from the cycle after START acceptance until DONE.
- DONE  out  1  one-cycle completion strobe.
- OVERRUN  out  1  sticky error flag, cleared on START acceptance.
- ECHO_CNT  out  ECHO_W  completed echoes in the current train.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE.
  - QSW_PULSE=0, BUSY=0, DONE=0, OVERRUN=0, ECHO_CNT=0.
  - Counters and latched config cleared.
- All outputs are registered. Control inputs are sampled on the ADC_CLK rising edge with no input synchroniser.
- States: IDLE, ARM, WAIT_ACQ, IN_ACQ, DELAY, PULSE, FIN.
- IDLE:
  - START=1 latches QSW_DELAY, QSW_WIDTH and NUM_ECHO; clears ECHO_CNT and OVERRUN; sets BUSY.
  - If latched NUM_ECHO==0, go to FIN; otherwise go to ARM.
  - START while not in IDLE is ignored. Config inputs are not re-sampled mid-train.
- ARM: wait for ACQ_WND=0, then go to WAIT_ACQ. This rejects a window already open at START.
- WAIT_ACQ: ACQ_WND=1 -> IN_ACQ.
- IN_ACQ: the edge E0 that samples ACQ_WND=0 loads the counter with the delay, then:
  - delay==0 and width>0: go to PULSE and set QSW_PULSE=1 at E0.
  - delay==0 and width==0: the echo completes at E0.
  - delay>0: go to DELAY.
- Pulse timing:
  - QSW_PULSE rises at edge E0+delay and falls at edge E0+delay+width.
  - High for exactly width cycles. width==0 means no pulse; the echo completes at E0+delay.
- Echo completion:
  - Occurs on the edge where QSW_PULSE falls, or at the points given above when width==0.
  - ECHO_CNT increments on that edge.
  - If the new count equals NUM_ECHO, go to FIN; otherwise go to WAIT_ACQ.
- FIN: DONE=1 for one cycle, BUSY=0, go to IDLE. ECHO_CNT holds its final value until the next START acceptance.
- Overrun: ACQ_WND sampled 1 in DELAY or PULSE means the next window opened before the pulse finished. On that edge:
  - QSW_PULSE=0 and OVERRUN=1.
  - The current echo counts as complete (ECHO_CNT increments).
  - If the count now equals NUM_ECHO, go to FIN; otherwise go directly to IN_ACQ.
- ABORT=1 in any non-IDLE state, on the next edge:
  - QSW_PULSE=0, BUSY=0, state=IDLE.
  - No DONE strobe; ECHO_CNT and OVERRUN hold.
  - ABORT has priority over every other transition. START in the same cycle is ignored.
- Counters never wrap. The delay and width counters are loaded, decremented to 1, and the transition happens on the edge where the value is 1.
- QSW_PULSE is never high outside DELAY→PULSE sequencing and never high in IDLE, ARM or FIN.

Decomposition:
- Shared package nmr_qsw_pkg:
  - state encoding, one-hot 7-bit localparams S_IDLE..S_FIN;
  - default CNT_W and ECHO_W constants.
- One sub-module, nmr_qsw_down_counter (load, decrement, terminal-count flag, width CNT_W), reused for both the delay and width phases.

Test Plan:
- Reset mid-pulse:
  - Stimulus: assert RESET_N=0 while QSW_PULSE=1.
  - Required: all outputs 0 immediately, without waiting for a clock; after release, state is IDLE and START is accepted.
- Normal train:
  - Stimulus: NUM_ECHO=3, DELAY=4, WIDTH=10; three 50-cycle ACQ_WND windows separated by 40 cycles.
  - Required: each QSW_PULSE rises exactly 4 edges after the falling-edge sample and is 10 cycles wide; ECHO_CNT goes 1, 2, 3; DONE pulses once; BUSY falls with DONE.
- Zero-delay and zero-width cases:
  - DELAY=0, WIDTH=5: pulse rises on the same edge that samples ACQ_WND=0.
  - WIDTH=0: no pulse, but ECHO_CNT still increments. NUM_ECHO=0: DONE one cycle after START, and no pulses.
- Overrun:
  - Stimulus: DELAY=10, WIDTH=30, next window 20 cycles after the previous one closes.
  - Required: QSW_PULSE drops the edge ACQ_WND=1 is sampled, OVERRUN=1 stays sticky, the echo is counted, and the next pulse fires normally.
- ARM and ignored START:
  - Stimulus: START with ACQ_WND already high.
  - Required: no pulse at that window's close; the first pulse follows the next full window. A second START while BUSY changes nothing.
- ABORT during DELAY:
  - Required: BUSY=0 the next cycle; no DONE; no pulse; ECHO_CNT unchanged; a fresh START then runs a full train.

Source files
------------

// File: rtl/nmr_qsw_pkg.sv
// nmr_qsw_pkg: shared constants for the Q-switch damping-pulse sequencer.
//   - one-hot state codes S_IDLE..S_FIN and the state_t enum built on them
//   - default counter widths
package nmr_qsw_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int ECHO_W_DEF = 16;

  localparam logic [6:0] S_IDLE     = 7'b000_0001;
  localparam logic [6:0] S_ARM      = 7'b000_0010;
  localparam logic [6:0] S_WAIT_ACQ = 7'b000_0100;
  localparam logic [6:0] S_IN_ACQ   = 7'b000_1000;
  localparam logic [6:0] S_DELAY    = 7'b001_0000;
  localparam logic [6:0] S_PULSE    = 7'b010_0000;
  localparam logic [6:0] S_FIN      = 7'b100_0000;

  typedef enum logic [6:0] {
    ST_IDLE     = S_IDLE,
    ST_ARM      = S_ARM,
    ST_WAIT_ACQ = S_WAIT_ACQ,
    ST_IN_ACQ   = S_IN_ACQ,
    ST_DELAY    = S_DELAY,
    ST_PULSE    = S_PULSE,
    ST_FIN      = S_FIN
  } state_t;
endpackage

// File: rtl/nmr_qsw_down_counter.sv
// nmr_qsw_down_counter: loadable down counter shared by the delay and width
// phases of the Q-switch pulse.
//   gclk, grst_n : clock, async active-low reset
//   load/load_val: load a new count (load wins over dec)
//   dec          : decrement; holds at zero, never wraps
//   cnt, tc      : current count, terminal flag (count == 1)
module nmr_qsw_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  // The phase ends on the edge that sees 1, so a load of N spans N edges.
  assign tc = (cnt == CNT_W'(1));
endmodule

// File: rtl/nmr_qsw_sequencer.sv
// nmr_qsw_sequencer: fires one Q-switch damping pulse after each CPMG
// acquisition window and counts echoes until the programmed train length.
//   adc_clk, reset_n       : clock, async active-low reset
//   start, abort           : train request (idle only) / level abort
//   acq_wnd                : acquisition window, already on adc_clk
//   qsw_delay, qsw_width   : window close -> pulse start, pulse length
//   num_echo               : echoes per train
//   qsw_pulse              : registered Q-switch enable
//   busy, done, overrun    : train active, completion strobe, sticky error
//   echo_cnt               : echoes completed in the current train
module nmr_qsw_sequencer import nmr_qsw_pkg::*; #(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ECHO_W = ECHO_W_DEF
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              acq_wnd,
  input  logic [CNT_W-1:0]  qsw_delay,
  input  logic [CNT_W-1:0]  qsw_width,
  input  logic [ECHO_W-1:0] num_echo,
  output logic              qsw_pulse,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ECHO_W-1:0] echo_cnt
);
  state_t             state;
  logic [CNT_W-1:0]   dly_q, wid_q;
  logic [ECHO_W-1:0]  num_q;
  logic               cnt_load, cnt_dec, cnt_tc;
  logic [CNT_W-1:0]   cnt_val, cnt;
  logic [ECHO_W-1:0]  cnt_next;
  logic               last;

  assign cnt_next = echo_cnt + 1'b1;
  assign last     = (cnt_next == num_q);

  // One counter serves both phases: loaded with the delay at window close
  // (or the width directly when delay is zero), reloaded with the width
  // on the edge the delay expires.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = wid_q;
    unique case (state)
      ST_IN_ACQ: if (!acq_wnd) begin
        cnt_load = 1'b1;
        cnt_val  = (dly_q != '0) ? dly_q : wid_q;
      end
      ST_DELAY: begin
        cnt_dec  = 1'b1;
        cnt_load = cnt_tc && !acq_wnd;
      end
      ST_PULSE: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  nmr_qsw_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .gclk     (adc_clk),
    .grst_n   (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      dly_q     <= '0;
      wid_q     <= '0;
      num_q     <= '0;
      qsw_pulse <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      echo_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state     <= ST_IDLE;
        qsw_pulse <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: if (start && !abort) begin
            dly_q    <= qsw_delay;
            wid_q    <= qsw_width;
            num_q    <= num_echo;
            echo_cnt <= '0;
            overrun  <= 1'b0;
            busy     <= 1'b1;
            state    <= (num_echo == '0) ? ST_FIN : ST_ARM;
          end
          // A window already open at START is skipped entirely.
          ST_ARM:      if (!acq_wnd) state <= ST_WAIT_ACQ;
          ST_WAIT_ACQ: if (acq_wnd)  state <= ST_IN_ACQ;
          ST_IN_ACQ: if (!acq_wnd) begin
            if (dly_q != '0) begin
              state <= ST_DELAY;
            end else if (wid_q != '0) begin
              state     <= ST_PULSE;
              qsw_pulse <= 1'b1;
            end else begin
              echo_cnt <= cnt_next;
              state    <= last ? ST_FIN : ST_WAIT_ACQ;
            end
          end
          ST_DELAY, ST_PULSE: begin
            if (acq_wnd) begin
              // Next window opened early: cut the pulse, count the echo and
              // treat this edge as the start of the new window.
              qsw_pulse <= 1'b0;
              overrun   <= 1'b1;
              echo_cnt  <= cnt_next;
              state     <= last ? ST_FIN : ST_IN_ACQ;
            end else if (cnt_tc) begin
              if (state == ST_DELAY && wid_q != '0) begin
                state     <= ST_PULSE;
                qsw_pulse <= 1'b1;
              end else begin
                qsw_pulse <= 1'b0;
                echo_cnt  <= cnt_next;
                state     <= last ? ST_FIN : ST_WAIT_ACQ;
              end
            end
          end
          ST_FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nmr_qsw_sequencer.sv
// tb_nmr_qsw_sequencer: table-driven trains, hand-written corner sequences
// and random stimulus, all checked every cycle against a timestamp-based
// behavioural model of the sequencer.
module tb_nmr_qsw_sequencer;
  localparam int CW = 16;
  localparam int EW = 16;

  logic          adc_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0, abort = 1'b0, acq_wnd = 1'b0;
  logic [CW-1:0] qsw_delay = '0, qsw_width = '0;
  logic [EW-1:0] num_echo = '0;
  logic          qsw_pulse, busy, done, overrun;
  logic [EW-1:0] echo_cnt;

  nmr_qsw_sequencer #(.CNT_W(CW), .ECHO_W(EW)) dut (
    .adc_clk  (adc_clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .acq_wnd  (acq_wnd),
    .qsw_delay(qsw_delay),
    .qsw_width(qsw_width),
    .num_echo (num_echo),
    .qsw_pulse(qsw_pulse),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .echo_cnt (echo_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int nvec = 0, nerr = 0;
  int rises = 0, hi = 0, dones = 0;
  bit qsw_prev = 1'b0;

  // Reference model: pulse placement from absolute edge timestamps
  // (rise = close edge + delay, end = rise + width).
  localparam int M_IDLE = 0, M_ARM = 1, M_WAIT = 2, M_IN = 3, M_TIMED = 4, M_FIN = 5;
  int cyc = 0;
  int m_mode = M_IDLE;
  int m_d = 0, m_w = 0, m_n = 0, m_rise = 0, m_end = 0, m_cnt = 0;
  bit m_qsw = 0, m_busy = 0, m_done = 0, m_ovr = 0;

  task automatic m_echo(input int nxt);
    m_cnt++;
    m_qsw  = 1'b0;
    m_mode = (m_cnt == m_n) ? M_FIN : nxt;
  endtask

  always @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_IDLE; m_qsw = 0; m_busy = 0; m_done = 0; m_ovr = 0; m_cnt = 0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (abort) begin
        if (m_mode != M_IDLE) begin m_mode = M_IDLE; m_qsw = 0; m_busy = 0; end
      end else begin
        case (m_mode)
          M_IDLE: if (start) begin
            m_d = int'(qsw_delay); m_w = int'(qsw_width); m_n = int'(num_echo);
            m_cnt = 0; m_ovr = 0; m_busy = 1;
            m_mode = (m_n == 0) ? M_FIN : M_ARM;
          end
          M_ARM:  if (!acq_wnd) m_mode = M_WAIT;
          M_WAIT: if (acq_wnd)  m_mode = M_IN;
          M_IN: if (!acq_wnd) begin
            m_rise = cyc + m_d;
            m_end  = m_rise + m_w;
            if (m_end == cyc) m_echo(M_WAIT);
            else begin m_mode = M_TIMED; m_qsw = (cyc >= m_rise); end
          end
          M_TIMED: begin
            if (acq_wnd) begin m_ovr = 1; m_echo(M_IN); end
            else if (cyc == m_end) m_echo(M_WAIT);
            else m_qsw = (cyc >= m_rise);
          end
          M_FIN: begin m_done = 1; m_busy = 0; m_mode = M_IDLE; end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every clock wait goes through here: compare against the model, then
  // update pulse / done monitors.
  task automatic tick();
    @(negedge adc_clk);
    chk("model {qsw,busy,done,ovr,cnt}",
        {qsw_pulse, busy, done, overrun, echo_cnt},
        {m_qsw, m_busy, m_done, m_ovr, EW'(m_cnt)});
    if (qsw_pulse && !qsw_prev) rises++;
    if (qsw_pulse) hi++;
    if (done) dones++;
    qsw_prev = qsw_pulse;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 600 && busy; k++) tick();
    chk(nm, busy, 0);
    tick();
  endtask

  typedef struct {
    int num, dly, wid, wlen, gap;
    int e_cnt, e_pul, e_hi, e_ovr, e_first;
  } vec_t;
  vec_t tbl[7];

  task automatic run_row(input int idx);
    vec_t v;
    int r0, h0, d0, first, e0;
    v = tbl[idx];
    r0 = rises; h0 = hi; d0 = dones; first = -1; e0 = 0;
    qsw_delay = CW'(v.dly); qsw_width = CW'(v.wid); num_echo = EW'(v.num);
    start = 1; tick(); start = 0; tick();
    for (int i = 0; i < ((v.num == 0) ? 1 : v.num); i++) begin
      acq_wnd = 1; repeat (v.wlen) tick();
      acq_wnd = 0; e0 = cyc + 1;
      for (int g = 0; g < v.gap; g++) begin
        tick();
        if (i == 0 && qsw_pulse && first < 0) first = cyc - e0;
      end
    end
    wait_idle($sformatf("row%0d busy_timeout", idx));
    chk($sformatf("row%0d echo_cnt", idx), echo_cnt, v.e_cnt);
    chk($sformatf("row%0d pulses", idx), rises - r0, v.e_pul);
    chk($sformatf("row%0d high_cycles", idx), hi - h0, v.e_hi);
    chk($sformatf("row%0d done_count", idx), dones - d0, 1);
    chk($sformatf("row%0d overrun", idx), overrun, v.e_ovr);
    chk($sformatf("row%0d first_rise", idx), first, v.e_first);
  endtask

  initial begin
    int r0, h0, d0, first, e0, acq_left;
    //           num dly wid wlen gap  cnt pul hi ovr first
    tbl[0] = '{3,  4, 10, 50, 40,  3,  3, 30, 0,  4};  // normal train
    tbl[1] = '{2,  0,  5,  8, 20,  2,  2, 10, 0,  0};  // zero delay
    tbl[2] = '{2,  3,  0,  6, 10,  2,  0,  0, 0, -1};  // zero width
    tbl[3] = '{0,  2,  3,  6, 10,  0,  0,  0, 0, -1};  // zero echoes
    tbl[4] = '{3, 10, 30, 15, 20,  3,  3, 50, 1, 10};  // overrun
    tbl[5] = '{1,  1,  1,  3,  5,  1,  1,  1, 0,  1};  // minimum timing
    tbl[6] = '{2,  0,  0,  4,  4,  2,  0,  0, 0, -1};  // zero delay+width

    #1 reset_n = 0;
    repeat (3) tick();
    chk("reset_state", {qsw_pulse, busy, done, overrun, echo_cnt}, 0);
    reset_n = 1;
    tick();

    for (int i = 0; i < 7; i++) run_row(i);

    // Async reset while the pulse is high.
    qsw_delay = 2; qsw_width = 20; num_echo = 1;
    start = 1; tick(); start = 0; tick();
    acq_wnd = 1; repeat (4) tick(); acq_wnd = 0;
    for (int k = 0; k < 10 && !qsw_pulse; k++) tick();
    chk("rst_pulse_high", qsw_pulse, 1);
    #2 reset_n = 0;
    #1 chk("rst_async_outputs", {qsw_pulse, busy, done, overrun, echo_cnt}, 0);
    tick(); tick();
    reset_n = 1;
    tick();
    run_row(5);

    // START inside an open window, plus an ignored second START.
    qsw_delay = 3; qsw_width = 4; num_echo = 1;
    acq_wnd = 1; tick();
    start = 1; tick(); start = 0;
    r0 = rises;
    qsw_delay = 0; num_echo = 5;
    start = 1; tick(); start = 0;
    repeat (5) tick();
    acq_wnd = 0; repeat (12) tick();
    chk("arm_no_pulse", rises - r0, 0);
    chk("arm_still_busy", busy, 1);
    acq_wnd = 1; repeat (6) tick();
    acq_wnd = 0; e0 = cyc + 1; first = -1; h0 = hi;
    for (int g = 0; g < 15; g++) begin
      tick();
      if (qsw_pulse && first < 0) first = cyc - e0;
    end
    chk("arm_rise_offset", first, 3);
    chk("arm_width", hi - h0, 4);
    wait_idle("arm_busy_timeout");
    chk("arm_echo_cnt", echo_cnt, 1);

    // Abort during the delay phase.
    qsw_delay = 20; qsw_width = 5; num_echo = 2;
    start = 1; tick(); start = 0; tick();
    acq_wnd = 1; repeat (4) tick(); acq_wnd = 0;
    repeat (5) tick();
    d0 = dones; r0 = rises;
    abort = 1; tick(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_echo_cnt", echo_cnt, 0);
    repeat (30) tick();
    chk("abort_no_done", dones - d0, 0);
    chk("abort_no_pulse", rises - r0, 0);
    run_row(0);

    // Random stimulus: windows, START/ABORT spam, config churn mid-train.
    acq_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (acq_left == 0) begin
        acq_wnd  = !acq_wnd;
        acq_left = $urandom_range(1, 14);
      end else acq_left--;
      start     = ($urandom_range(0, 24) == 0);
      abort     = ($urandom_range(0, 199) == 0);
      qsw_delay = CW'($urandom_range(0, 6));
      qsw_width = CW'($urandom_range(0, 6));
      num_echo  = EW'($urandom_range(0, 4));
      tick();
    end
    start = 0; abort = 0; acq_wnd = 0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
